// File: rtl/line_write_merge_buffer_if.sv
// Bus bundle for the line write-merge buffer: L1 write port, L2 drain port,
// flush control, forwarding lookup probe and occupancy status.
interface line_write_merge_buffer_if #(
  parameter int LINE_BITS = 128,
  parameter int WORD_BITS = 16,
  parameter int ADDR_BITS = 16,
  parameter int ENTRIES   = 4
) ();
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int TAG_W = ADDR_BITS - OFF;
  localparam int CNT_W = $clog2(ENTRIES) + 1;

  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [WORD_BITS-1:0]   wr_data;
  logic [WORD_BITS/8-1:0] wr_be;

  logic                   drain_valid;
  logic                   drain_ready;
  logic [TAG_W-1:0]       drain_tag;
  logic [LINE_BITS-1:0]   drain_data;
  logic [LINE_BITS/8-1:0] drain_mask;

  logic                   flush;
  logic [ADDR_BITS-1:0]   lookup_addr;
  logic                   lookup_hit;
  logic                   empty;
  logic [CNT_W-1:0]       count;

  // Requester side: issues writes, accepts drained lines, probes and flushes.
  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, drain_ready, flush, lookup_addr,
    input  wr_ready, drain_valid, drain_tag, drain_data, drain_mask,
           lookup_hit, empty, count
  );

  // Buffer side.
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be, drain_ready, flush, lookup_addr,
    output wr_ready, drain_valid, drain_tag, drain_data, drain_mask,
           lookup_hit, empty, count
  );
endinterface

// File: rtl/line_write_merge_buffer.sv
// Line write-merge buffer: gathers byte-enabled word writes into line-sized
// FIFO entries keyed by line address, tracks a per-byte valid mask, and drains
// whole lines in order over a valid/ready handshake. A committed (locked) head
// is frozen so the drain outputs stay stable until accepted.
module line_write_merge_buffer #(
  parameter int LINE_BITS = 128,
  parameter int WORD_BITS = 16,
  parameter int ADDR_BITS = 16,
  parameter int ENTRIES   = 4,
  parameter int AGE_MAX   = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  line_write_merge_buffer_if.slave bus
);
  localparam int BYTES  = LINE_BITS / 8;
  localparam int WB     = WORD_BITS / 8;
  localparam int OFF    = $clog2(BYTES);
  localparam int WOFF   = $clog2(WB);
  localparam int NWORDS = LINE_BITS / WORD_BITS;
  localparam int IDX_W  = OFF - WOFF;
  localparam int TAG_W  = ADDR_BITS - OFF;
  localparam int PTR_W  = $clog2(ENTRIES);
  localparam int CNT_W  = PTR_W + 1;
  localparam int AGE_W  = $clog2(AGE_MAX + 1);

  // Control state (reset)
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               flush_pend_q, flush_pend_d;
  logic               lock_q, lock_d;

  // Entry payload (not reset; always qualified by valid_q)
  logic [TAG_W-1:0]     tag_q  [ENTRIES];
  logic [LINE_BITS-1:0] data_q [ENTRIES];
  logic [BYTES-1:0]     mask_q [ENTRIES];

  logic [TAG_W-1:0]     wr_tag;
  logic [IDX_W-1:0]     wr_widx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 commit;
  logic                 merge_hit;
  logic [PTR_W-1:0]     merge_idx;
  logic [PTR_W-1:0]     wr_idx;
  logic                 wr_ready;
  logic                 wr_fire, do_merge, do_alloc, drain_fire;
  logic [LINE_BITS-1:0] new_line;
  logic [BYTES-1:0]     new_mask;
  logic                 lookup_hit;

  assign wr_tag  = bus.wr_addr[ADDR_BITS-1:OFF];
  assign wr_widx = bus.wr_addr[OFF-1:WOFF];
  assign lk_tag  = bus.lookup_addr[ADDR_BITS-1:OFF];

  // Sub-word address bits carry no information for this buffer.
  logic unused_addr_bits;
  if (WOFF > 0) begin : g_wofs
    assign unused_addr_bits = ^{bus.wr_addr[WOFF-1:0], bus.lookup_addr[OFF-1:0]};
  end else begin : g_nowofs
    assign unused_addr_bits = ^bus.lookup_addr[OFF-1:0];
  end

  // The head is offered for drain once committed; a commit stays in force
  // (lock_q) until the line is accepted, which freezes the head contents.
  assign commit = valid_q[head_q] &&
                  (lock_q || (count_q >= CNT_W'(2)) || flush_pend_q ||
                   (age_q == AGE_W'(AGE_MAX)));

  // Find the newest unlocked valid entry holding the write's line; walking
  // from head toward tail lets later matches override earlier ones.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[head_q + PTR_W'(i)] && (tag_q[head_q + PTR_W'(i)] == wr_tag) &&
          !(commit && (i == 0))) begin
        merge_hit = 1'b1;
        merge_idx = head_q + PTR_W'(i);
      end
    end
  end

  // Ready depends only on registered state and the write address, never on
  // drain_ready: a slot freed by a drain is usable from the following cycle.
  assign wr_ready   = merge_hit || (count_q < CNT_W'(ENTRIES));
  assign wr_fire    = bus.wr_valid && wr_ready && (|bus.wr_be);
  assign do_merge   = wr_fire && merge_hit;
  assign do_alloc   = wr_fire && !merge_hit;
  assign drain_fire = commit && bus.drain_ready;
  assign wr_idx     = merge_hit ? merge_idx : tail_q;

  // Build the updated line: start from the matched entry (or zero for a new
  // allocation) and overlay only the byte lanes enabled in the written word.
  always_comb begin
    new_line = merge_hit ? data_q[merge_idx] : '0;
    new_mask = merge_hit ? mask_q[merge_idx] : '0;
    for (int w = 0; w < NWORDS; w++) begin
      for (int k = 0; k < WB; k++) begin
        if ((IDX_W'(w) == wr_widx) && bus.wr_be[k]) begin
          new_line[(w*WB + k)*8 +: 8] = bus.wr_data[k*8 +: 8];
          new_mask[w*WB + k]          = 1'b1;
        end
      end
    end
  end

  // Next-state for pointers, occupancy, head age, lock and pending flush.
  always_comb begin
    valid_d = valid_q;
    if (drain_fire) valid_d[head_q] = 1'b0;
    if (do_alloc)   valid_d[tail_q] = 1'b1;

    head_d  = head_q + PTR_W'(drain_fire);
    tail_d  = tail_q + PTR_W'(do_alloc);
    count_d = count_q + CNT_W'(do_alloc) - CNT_W'(drain_fire);
    lock_d  = commit && !drain_fire;

    if ((count_q == '0) || drain_fire)
      age_d = '0;
    else if (!commit && (age_q != AGE_W'(AGE_MAX)))
      age_d = age_q + AGE_W'(1);
    else
      age_d = age_q;

    if (count_d == '0)
      flush_pend_d = 1'b0;
    else if (bus.flush && (count_q != '0))
      flush_pend_d = 1'b1;
    else
      flush_pend_d = flush_pend_q;
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      age_q        <= '0;
      flush_pend_q <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      age_q        <= age_d;
      flush_pend_q <= flush_pend_d;
      lock_q       <= lock_d;
    end
  end

  // Entry payload write on merge or allocate.
  always_ff @(posedge clk) begin
    if (do_merge || do_alloc) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= new_line;
      mask_q[wr_idx] <= new_mask;
    end
  end

  // Forwarding probe over all valid entries.
  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == lk_tag)) lookup_hit = 1'b1;
    end
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.drain_valid = commit;
  assign bus.drain_tag   = commit ? tag_q[head_q]  : '0;
  assign bus.drain_data  = commit ? data_q[head_q] : '0;
  assign bus.drain_mask  = commit ? mask_q[head_q] : '0;
  assign bus.lookup_hit  = lookup_hit;
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0) && !flush_pend_q;
endmodule
